// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM states, multiply length.
package exec_pkg;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;
    localparam logic [4:0] ALU_SRA = 5'd9;
    localparam logic [4:0] ALU_MUL = 5'd10;
    localparam logic [4:0] ALU_LUI = 5'd11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } exec_state_t;

    localparam int unsigned MUL_ITERS = 32;

endpackage

// File: rtl/execute_stage_mul_seq.sv
// Shift-add sequential multiplier datapath; one iteration per cycle while step is high.
module mul_seq
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(MUL_ITERS);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] prod;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    // done marks the cycle performing the final iteration
    assign done    = step && (count == CNT_W'(MUL_ITERS - 1));
    assign product = prod;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, sequential multiply and EX/MEM register.
// Optional feature: EXEC_FORWARD_EN enables the MEM/WB forwarding muxes.
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWriteEx,
    input  logic              ALUSrcEx,
    input  logic              MemToRegEx,
    input  logic [1:0]        MemWriteEx,
    input  logic [1:0]        MemReadEx,
    input  logic [4:0]        ALUControlEx,
    input  logic [DATA_W-1:0] ReadData1Ex,
    input  logic [DATA_W-1:0] ReadData2Ex,
    input  logic [DATA_W-1:0] SignExtEx,
    input  logic [4:0]        RSEx,
    input  logic [4:0]        RTEx,
    input  logic [4:0]        DestRegEx,
    input  logic              RegWriteMem,
    input  logic [4:0]        DestRegMem,
    input  logic [DATA_W-1:0] ALUResultMem,
    input  logic              RegWriteWb,
    input  logic [4:0]        DestRegWb,
    input  logic [DATA_W-1:0] WriteDataWb,
    output logic              ExStall,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic [1:0]        MemWriteOut,
    output logic [1:0]        MemReadOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [4:0]        DestRegOut
);

    exec_state_t       state;
    exec_state_t       state_next;
    logic              stall;
    logic              mul_start;
    logic              mul_step;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        shamt;

`ifdef EXEC_FORWARD_EN
    // MEM stage wins over WB; register 0 is never forwarded
    always_comb begin
        fwd_a = ReadData1Ex;
        if (RegWriteMem && (DestRegMem != '0) && (DestRegMem == RSEx)) begin
            fwd_a = ALUResultMem;
        end else if (RegWriteWb && (DestRegWb != '0) && (DestRegWb == RSEx)) begin
            fwd_a = WriteDataWb;
        end
    end

    always_comb begin
        fwd_b = ReadData2Ex;
        if (RegWriteMem && (DestRegMem != '0) && (DestRegMem == RTEx)) begin
            fwd_b = ALUResultMem;
        end else if (RegWriteWb && (DestRegWb != '0) && (DestRegWb == RTEx)) begin
            fwd_b = WriteDataWb;
        end
    end
`else
    logic unused_fwd;

    assign fwd_a      = ReadData1Ex;
    assign fwd_b      = ReadData2Ex;
    assign unused_fwd = ^{RegWriteMem, DestRegMem, ALUResultMem,
                          RegWriteWb, DestRegWb, WriteDataWb, RSEx, RTEx};
`endif

    assign op_b  = ALUSrcEx ? SignExtEx : fwd_b;
    assign shamt = SignExtEx[10:6];

    always_comb begin
        alu_result = '0;
        case (ALUControlEx)
            ALU_ADD: alu_result = fwd_a + op_b;
            ALU_SUB: alu_result = fwd_a - op_b;
            ALU_AND: alu_result = fwd_a & op_b;
            ALU_OR:  alu_result = fwd_a | op_b;
            ALU_XOR: alu_result = fwd_a ^ op_b;
            ALU_NOR: alu_result = ~(fwd_a | op_b);
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLL: alu_result = op_b << shamt;
            ALU_SRL: alu_result = op_b >> shamt;
            ALU_SRA: alu_result = $signed(op_b) >>> shamt;
            ALU_LUI: alu_result = op_b << 16;
            default: alu_result = '0;
        endcase
    end

    mul_seq #(
        .DATA_W(DATA_W)
    ) u_mul_seq (
        .clk    (Clk),
        .reset  (Reset),
        .start  (mul_start),
        .step   (mul_step),
        .a      (fwd_a),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        case (state)
            IDLE: begin
                if (ALUControlEx == ALU_MUL) begin
                    stall      = 1'b1;
                    mul_start  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall    = 1'b1;
                mul_step = 1'b1;
                if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ExStall = stall;

    // Stall cycles push a bubble; DONE captures the product with the still-frozen ID/EX control
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            MemWriteOut  <= '0;
            MemReadOut   <= '0;
            ALUResultOut <= '0;
            WriteDataOut <= '0;
            DestRegOut   <= '0;
        end else begin
            RegWriteOut  <= RegWriteEx && !stall;
            MemToRegOut  <= MemToRegEx;
            MemWriteOut  <= stall ? 2'b00 : MemWriteEx;
            MemReadOut   <= stall ? 2'b00 : MemReadEx;
            ALUResultOut <= (state == DONE) ? mul_product : alu_result;
            WriteDataOut <= fwd_b;
            DestRegOut   <= DestRegEx;
        end
    end

endmodule
